bus_sequencer: RTL and testbench

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/reg_select_decoder.sv | 17 +
 rtl/bus_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_bus_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the control-unit sequencer.
//   - opcode constants (5-bit opcode field of the instruction register)
//   - instruction-register field positions (opcode, ra, rb, rc)
//   - sequencer state enum
//   - helpers that classify opcodes
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_HALT
  } state_t;

  // Two-source ALU ops that write one GPR result.
  function automatic logic is_single_op(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                      OP_SHR, OP_SHL, OP_ROR, OP_ROL};
  endfunction

  // Ops producing a HI/LO result pair.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: 4-to-16 one-hot decoder with enable.
// Ports:
//   en     in  1   when low, onehot is all zeros
//   sel    in  4   register index
//   onehot out 16  one-hot select (bit sel set when en=1)
module reg_select_decoder (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: control-unit FSM that sequences fetch (T0..T2) and
// execute (T3..T6) steps of a single-bus CPU datapath, producing register
// drive/load enables decoded from state, ir and mem_rdy.
//
// Ports:
//   clock, clear                 clock; async active-high reset
//   run                          level enable for starting instructions
//   ir[31:0]                     instruction (opcode/ra/rb/rc fields)
//   mem_rdy                      memory read data valid
//   r_out[15:0], *_out           one-hot bus drive enables
//   r_in[15:0], *_in             register load enables
//   inc_pc, read                 PC-increment select; memory read strobe
//   alu_op[4:0]                  opcode presented to the ALU in T4
//   done                         pulse on an instruction's final step
//   halted                       high while in HALT
//   state                        current FSM state (debug visibility)
//
// Handshake: mem_rdy is a valid qualifier for the read issued in T1; the
// sequencer holds T1 with read asserted until mem_rdy=1, and loads the
// MDR in that same cycle. There is no back-pressure toward memory.
//
// Build option: define SEQ_MULDIV_EN to sequence MUL/DIV through T6
// (LO then HI); otherwise MUL/DIV decode as unknown opcodes.
module bus_sequencer
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic [15:0] r_out,
  output logic        hi_out,
  output logic        lo_out,
  output logic        zhigh_out,
  output logic        zlow_out,
  output logic        pc_out,
  output logic        mdr_out,
  output logic [15:0] r_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        inc_pc,
  output logic        read,
  output logic [4:0]  alu_op,
  output logic        done,
  output logic        halted,
  output state_t      state
);

  state_t     next_state;
  logic       t1_wait;      // set after a stalled T1 cycle: not the first
  logic       muldiv;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       rsel_out_en, rsel_in_en;
  logic [3:0] rsel_out, rsel_in;
  logic       unused_ir_bits;

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign ra     = ir[RA_MSB:RA_LSB];
  assign rb     = ir[RB_MSB:RB_LSB];
  assign rc     = ir[RC_MSB:RC_LSB];
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

`ifdef SEQ_MULDIV_EN
  assign muldiv = is_muldiv(opcode);
`else
  assign muldiv = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= ST_IDLE;
      t1_wait <= 1'b0;
    end else begin
      state   <= next_state;
      t1_wait <= (state == ST_T1) && !mem_rdy;
    end
  end

  always_comb begin
    next_state  = state;
    rsel_out_en = 1'b0;
    rsel_out    = '0;
    rsel_in_en  = 1'b0;
    rsel_in     = '0;
    hi_out      = 1'b0;
    lo_out      = 1'b0;
    zhigh_out   = 1'b0;
    zlow_out    = 1'b0;
    pc_out      = 1'b0;
    mdr_out     = 1'b0;
    hi_in       = 1'b0;
    lo_in       = 1'b0;
    pc_in       = 1'b0;
    ir_in       = 1'b0;
    mar_in      = 1'b0;
    mdr_in      = 1'b0;
    y_in        = 1'b0;
    z_in        = 1'b0;
    inc_pc      = 1'b0;
    read        = 1'b0;
    alu_op      = '0;
    done        = 1'b0;
    halted      = 1'b0;

    unique case (state)
      ST_IDLE: if (run) next_state = ST_T0;
      ST_T0: begin
        pc_out     = 1'b1;
        mar_in     = 1'b1;
        inc_pc     = 1'b1;
        z_in       = 1'b1;
        next_state = ST_T1;
      end
      ST_T1: begin
        read = 1'b1;
        // Incremented PC is written back only once, however long the stall.
        if (!t1_wait) begin
          zlow_out = 1'b1;
          pc_in    = 1'b1;
        end
        if (mem_rdy) begin
          mdr_in     = 1'b1;
          next_state = ST_T2;
        end
      end
      ST_T2: begin
        mdr_out    = 1'b1;
        ir_in      = 1'b1;
        next_state = ST_T3;
      end
      ST_T3: begin
        if (is_single_op(opcode) || muldiv) begin
          rsel_out_en = 1'b1;
          rsel_out    = muldiv ? ra : rb;
          y_in        = 1'b1;
          next_state  = ST_T4;
        end else if (opcode == OP_HALT) begin
          next_state = ST_HALT;
        end else begin
          done       = 1'b1;
          next_state = run ? ST_T0 : ST_IDLE;
        end
      end
      ST_T4: begin
        rsel_out_en = 1'b1;
        rsel_out    = muldiv ? rb : rc;
        z_in        = 1'b1;
        alu_op      = opcode;
        next_state  = ST_T5;
      end
      ST_T5: begin
        zlow_out = 1'b1;
        if (muldiv) begin
          lo_in      = 1'b1;
          next_state = ST_T6;
        end else begin
          rsel_in_en = 1'b1;
          rsel_in    = ra;
          done       = 1'b1;
          next_state = run ? ST_T0 : ST_IDLE;
        end
      end
      ST_T6: begin
        if (muldiv) begin
          zhigh_out  = 1'b1;
          hi_in      = 1'b1;
          done       = 1'b1;
          next_state = run ? ST_T0 : ST_IDLE;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_HALT: halted = 1'b1;
      default: next_state = ST_IDLE;
    endcase
  end

  reg_select_decoder u_out_dec (
    .en     (rsel_out_en),
    .sel    (rsel_out),
    .onehot (r_out)
  );

  reg_select_decoder u_in_dec (
    .en     (rsel_in_en),
    .sel    (rsel_in),
    .onehot (r_in)
  );

endmodule

// File: tb/tb_bus_sequencer.sv
module tb_bus_sequencer;
  import cpu_pkg::*;

  typedef struct packed {
    state_t      st;
    logic [15:0] r_out;
    logic        hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out;
    logic [15:0] r_in;
    logic        hi_in, lo_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in;
    logic        inc_pc, read;
    logic [4:0]  alu_op;
    logic        done, halted;
  } obs_t;

  localparam int OW = $bits(obs_t);

  logic        clock;
  logic        clear;
  logic        run;
  logic [31:0] ir;
  logic        mem_rdy;
  logic [15:0] r_out, r_in;
  logic        hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out;
  logic        hi_in, lo_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in;
  logic        inc_pc, read, done, halted;
  logic [4:0]  alu_op;
  state_t      dut_state;

  obs_t act;

  logic [OW-1:0] exp_q[$];
  string         tag_q[$];
  int            total = 0;
  int            bad   = 0;

  bus_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_rdy(mem_rdy),
    .r_out(r_out), .hi_out(hi_out), .lo_out(lo_out), .zhigh_out(zhigh_out),
    .zlow_out(zlow_out), .pc_out(pc_out), .mdr_out(mdr_out),
    .r_in(r_in), .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .ir_in(ir_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in),
    .inc_pc(inc_pc), .read(read), .alu_op(alu_op), .done(done),
    .halted(halted), .state(dut_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    act           = '0;
    act.st        = dut_state;
    act.r_out     = r_out;
    act.hi_out    = hi_out;
    act.lo_out    = lo_out;
    act.zhigh_out = zhigh_out;
    act.zlow_out  = zlow_out;
    act.pc_out    = pc_out;
    act.mdr_out   = mdr_out;
    act.r_in      = r_in;
    act.hi_in     = hi_in;
    act.lo_in     = lo_in;
    act.pc_in     = pc_in;
    act.ir_in     = ir_in;
    act.mar_in    = mar_in;
    act.mdr_in    = mdr_in;
    act.y_in      = y_in;
    act.z_in      = z_in;
    act.inc_pc    = inc_pc;
    act.read      = read;
    act.alu_op    = alu_op;
    act.done      = done;
    act.halted    = halted;
  end

  // Monitor: one-hot checks every cycle, and scoreboard pop when an
  // expectation is queued. Also fires on a rising clear to catch the
  // asynchronous response.
  always @(negedge clock or posedge clear) begin
    obs_t  e;
    string t;
    #1;
    total++;
    assert ($countones({r_out, hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out}) <= 1
            && $countones(r_in) <= 1)
    else begin
      bad++;
      $display("FAIL bus_onehot t=%0t got r_out=%h outs=%b r_in=%h, required at most one bit each",
               $time, r_out, {hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out}, r_in);
    end
    if (exp_q.size() > 0) begin
      e = obs_t'(exp_q.pop_front());
      t = tag_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s t=%0t got=%h (state=%s) exp=%h (state=%s)",
                 t, $time, act, act.st.name(), e, e.st.name());
      end
    end
  end

  function automatic obs_t z(input state_t s);
    obs_t v;
    v    = '0;
    v.st = s;
    return v;
  endfunction

  // driver: apply inputs for this cycle and queue the expected outputs
  task automatic cyc(input logic r, input logic m, input obs_t v, input string tag);
    run     = r;
    mem_rdy = m;
    exp_q.push_back(v);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic r, input int stalls);
    obs_t v;
    v = z(ST_T0); v.pc_out = 1; v.mar_in = 1; v.inc_pc = 1; v.z_in = 1;
    cyc(r, 1'b0, v, "t0");
    for (int i = 0; i <= stalls; i++) begin
      v = z(ST_T1); v.read = 1;
      if (i == 0) begin v.zlow_out = 1; v.pc_in = 1; end
      if (i == stalls) v.mdr_in = 1;
      cyc(r, (i == stalls), v, $sformatf("t1_%0d", i));
    end
    v = z(ST_T2); v.mdr_out = 1; v.ir_in = 1;
    cyc(r, 1'b1, v, "t2");
  endtask

  task automatic alu_tail(input logic r, input logic [15:0] ro3, input logic [15:0] ro4,
                          input logic [15:0] ri5, input logic [4:0] op, input string nm);
    obs_t v;
    v = z(ST_T3); v.r_out = ro3; v.y_in = 1;
    cyc(r, 1'b1, v, {nm, "_t3"});
    v = z(ST_T4); v.r_out = ro4; v.z_in = 1; v.alu_op = op;
    cyc(r, 1'b1, v, {nm, "_t4"});
    v = z(ST_T5); v.zlow_out = 1; v.r_in = ri5; v.done = 1;
    cyc(r, 1'b1, v, {nm, "_t5"});
  endtask

  initial begin
    obs_t v;
    clear   = 1'b1;
    run     = 1'b0;
    mem_rdy = 1'b0;
    ir      = '0;
    @(posedge clock);
    #1;
    // reset state
    cyc(1'b1, 1'b1, z(ST_IDLE), "reset_hold0");
    cyc(1'b1, 1'b1, z(ST_IDLE), "reset_hold1");
    clear = 1'b0;
    cyc(1'b0, 1'b0, z(ST_IDLE), "idle_norun0");
    cyc(1'b0, 1'b1, z(ST_IDLE), "idle_norun1");

    // add r3,r1,r2, then back-to-back sub r0,r5,r6 with a 3-cycle stall;
    // run drops mid-instruction and the sub still completes
    ir = 32'h19890000;
    cyc(1'b1, 1'b1, z(ST_IDLE), "add_go");
    fetch(1'b1, 0);
    alu_tail(1'b1, 16'h0002, 16'h0004, 16'h0008, 5'b00011, "add");
    ir = {OP_SUB, 4'd0, 4'd5, 4'd6, 15'd0};
    fetch(1'b1, 3);
    alu_tail(1'b0, 16'h0020, 16'h0040, 16'h0001, 5'b00100, "sub");
    cyc(1'b0, 1'b1, z(ST_IDLE), "idle_after_sub");

    // unknown opcode: done in T3, back to IDLE with run low
    ir = {5'b00000, 4'd1, 4'd2, 4'd3, 15'd0};
    cyc(1'b1, 1'b1, z(ST_IDLE), "unk_go");
    fetch(1'b1, 0);
    v = z(ST_T3); v.done = 1;
    cyc(1'b0, 1'b1, v, "unk_t3");
    cyc(1'b0, 1'b1, z(ST_IDLE), "idle_after_unk");

    // MUL ra=4 rb=7
    ir = {OP_MUL, 4'd4, 4'd7, 4'd0, 15'd0};
    cyc(1'b1, 1'b1, z(ST_IDLE), "mul_go");
    fetch(1'b1, 0);
`ifdef SEQ_MULDIV_EN
    v = z(ST_T3); v.r_out = 16'h0010; v.y_in = 1;
    cyc(1'b0, 1'b1, v, "mul_t3");
    v = z(ST_T4); v.r_out = 16'h0080; v.z_in = 1; v.alu_op = 5'b01111;
    cyc(1'b0, 1'b1, v, "mul_t4");
    v = z(ST_T5); v.zlow_out = 1; v.lo_in = 1;
    cyc(1'b0, 1'b1, v, "mul_t5");
    v = z(ST_T6); v.zhigh_out = 1; v.hi_in = 1; v.done = 1;
    cyc(1'b0, 1'b1, v, "mul_t6");
`else
    v = z(ST_T3); v.done = 1;
    cyc(1'b0, 1'b1, v, "mul_as_unknown_t3");
`endif
    cyc(1'b0, 1'b1, z(ST_IDLE), "idle_after_mul");

    // reset in T4 of an add: outputs drop in the same cycle, no r_in later
    ir = 32'h19890000;
    cyc(1'b1, 1'b1, z(ST_IDLE), "rst_add_go");
    fetch(1'b1, 0);
    v = z(ST_T3); v.r_out = 16'h0002; v.y_in = 1;
    cyc(1'b1, 1'b1, v, "rst_add_t3");
    v = z(ST_T4); v.r_out = 16'h0004; v.z_in = 1; v.alu_op = 5'b00011;
    exp_q.push_back(v);
    tag_q.push_back("rst_add_t4");
    @(negedge clock);
    #2;
    exp_q.push_back(z(ST_IDLE));
    tag_q.push_back("clear_in_t4");
    clear = 1'b1;
    @(posedge clock);
    #1;
    cyc(1'b0, 1'b1, z(ST_IDLE), "clear_hold");
    clear = 1'b0;
    cyc(1'b0, 1'b1, z(ST_IDLE), "after_clear0");
    cyc(1'b0, 1'b1, z(ST_IDLE), "after_clear1");

    // HALT: held regardless of run, left only by clear
    ir = {OP_HALT, 27'd0};
    cyc(1'b1, 1'b1, z(ST_IDLE), "halt_go");
    fetch(1'b1, 0);
    cyc(1'b1, 1'b1, z(ST_T3), "halt_t3");
    for (int i = 0; i < 4; i++) begin
      v = z(ST_HALT); v.halted = 1;
      cyc(i[0], 1'b1, v, $sformatf("halt_hold%0d", i));
    end
    exp_q.push_back(z(ST_IDLE));
    tag_q.push_back("halt_clear");
    clear = 1'b1;
    @(posedge clock);
    #1;
    cyc(1'b1, 1'b1, z(ST_IDLE), "halt_clear_hold");
    clear = 1'b0;
    run   = 1'b0;
    @(posedge clock);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
